round_robin_arbiter: RTL and testbench

- Registered N-way round-robin arbiter; default N=4.
- Each clock it grants exactly one active requester, or none if no requests.
- Priority rotates to start just after the most recently granted requester.
- Sits in front of a shared resource (bus, memory port); consumers treat grant as a one-hot select.

---
 rtl/round_robin_arbiter.sv | 86 ++++++++
 tb/tb_round_robin_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered N-way round-robin arbiter.
//   Each cycle it grants one active requester, or none when nothing is
//   requested. Priority starts just after the most recently granted index.
//   The grant is one-hot, so consumers can use it directly as a select.
//
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-high reset (grant=0, ptr=0)
//   req   in  N  request vector, bit i = requester i wants the resource
//   grant out N  registered one-hot grant, all-zero = no grant
//
// Build option:
//   RRA_HOLD_EN  lock mode. A grantee that keeps its request asserted keeps
//                the grant. Arbitration resumes from grantee+1 once it drops.

// Per-requester win decision. Requester IDX wins when it requests and no
// requester that is closer to ptr in the wrapped scan order also requests.
module rra_lane #(
  parameter int N   = 4,
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          win
);
  always_comb begin
    win = req[IDX];
    for (int j = 0; j < N; j++) begin
      // (x - ptr) mod N is x's position in the scan that starts at ptr
      if (j != IDX && req[j] &&
          ((j - int'(ptr) + N) % N) < ((IDX - int'(ptr) + N) % N))
        win = 1'b0;
    end
  end
endmodule

module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, ptr_nxt;
  logic [N-1:0]  win, grant_nxt;

  for (genvar i = 0; i < N; i++) begin : g_lane
    rra_lane #(.N(N), .PW(PW), .IDX(i)) u_lane (
      .req (req),
      .ptr (ptr),
      .win (win[i])
    );
  end

  always_comb begin
    grant_nxt = '0;
    ptr_nxt   = ptr;
    if (|req) begin
      grant_nxt = win;
      for (int i = 0; i < N; i++)
        if (win[i]) ptr_nxt = (i == N-1) ? '0 : PW'(i + 1);
    end
`ifdef RRA_HOLD_EN
    // grant is one-hot, so any overlap means the current grantee still
    // requests. ptr already points past it, so release resumes from i+1.
    if (|(grant & req)) begin
      grant_nxt = grant;
      ptr_nxt   = ptr;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      ptr   <= '0;
    end else begin
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Testbench for round_robin_arbiter (N=4). The stimulus process drives req
// on the falling edge and queues the grant expected after the next rising
// edge. A monitor pops one entry per rising edge and compares.
// Expectations cover both builds (RRA_HOLD_EN defined or not).
module tb_round_robin_arbiter;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] exp;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  round_robin_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: grant=%b expected=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive req for the next rising edge and queue the expected grant.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] e,
                      input string name);
    exp_t x;
    @(negedge clk);
    req    = r;
    x.exp  = e;
    x.name = name;
    q.push_back(x);
  endtask

  // Monitor: one comparison per rising edge while expectations are pending.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        check(x.name, grant, x.exp);
      end
    end
  end

  initial begin
    // 1: reset held, then idle after release
    step(4'b0000, 4'b0000, "rst_hold0");
    step(4'b0000, 4'b0000, "rst_hold1");
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 4'b0000, "idle0");
    step(4'b0000, 4'b0000, "idle1");

`ifdef RRA_HOLD_EN
    // 2/6: all requesting, first grantee keeps the lock
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b0001, "hold_all");
    // 3: lock releases only when the grantee drops its request
    step(4'b1110, 4'b0010, "seq0");
    step(4'b0010, 4'b0010, "seq1");
    step(4'b0011, 4'b0010, "seq2");
    step(4'b0110, 4'b0010, "seq3");
    step(4'b0101, 4'b0100, "seq4");
    step(4'b0111, 4'b0100, "seq5");
    step(4'b1010, 4'b1000, "seq6");
    step(4'b0100, 4'b0100, "seq7");
`else
    // 2: full rotation and wrap
    step(4'b1111, 4'b0001, "all0");
    step(4'b1111, 4'b0010, "all1");
    step(4'b1111, 4'b0100, "all2");
    step(4'b1111, 4'b1000, "all3");
    step(4'b1111, 4'b0001, "all4");
    // 3: directed sequence starting at ptr=1
    step(4'b1110, 4'b0010, "seq0");
    step(4'b0010, 4'b0010, "seq1");
    step(4'b0011, 4'b0001, "seq2");
    step(4'b0110, 4'b0010, "seq3");
    step(4'b0101, 4'b0100, "seq4");
    step(4'b0111, 4'b0001, "seq5");
    step(4'b1010, 4'b0010, "seq6");
    step(4'b0100, 4'b0100, "seq7");
`endif

    // 4: asynchronous reset between edges while grant=0100
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = '0;
    #1;
    check("async_rst", grant, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1000, 4'b1000, "post_rst_n1");
`ifdef RRA_HOLD_EN
    step(4'b1111, 4'b1000, "post_rst_hold");
    step(4'b0111, 4'b0001, "post_rst_wrap");
`else
    step(4'b1111, 4'b0001, "post_rst_wrap");
`endif

    // 5: pointer survives idle cycles
    step(4'b0010, 4'b0010, "pre_idle");
    step(4'b0000, 4'b0000, "idle2");
    step(4'b0000, 4'b0000, "idle3");
    step(4'b1111, 4'b0100, "ptr_kept");

    // sole requesters are granted back-to-back
    step(4'b0100, 4'b0100, "sole2a");
    step(4'b0100, 4'b0100, "sole2b");
    step(4'b1000, 4'b1000, "sole3a");
    step(4'b1000, 4'b1000, "sole3b");
    step(4'b0000, 4'b0000, "idle_end");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
